// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encodings and flag bundle for the pipelined ALU.
package alu_pkg;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } flags_t;
endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU ops and flags; zero latency, no handshake.
// MUL is not handled here and yields y=0 so a MUL-less build reports flags on zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ctrl,
    output logic [WIDTH-1:0] y,
    output flags_t           flags
);
    localparam int SW = $clog2(WIDTH);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        y              = '0;
        flags.carry    = 1'b0;
        flags.overflow = 1'b0;
        case (ctrl)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_ADD: begin
                y              = w_sum[WIDTH-1:0];
                flags.carry    = w_sum[WIDTH];
                flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // carry reports a borrow, i.e. the inverted carry-out of a + ~b + 1
                y              = w_diff[WIDTH-1:0];
                flags.carry    = ~w_diff[WIDTH];
                flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SHL: y = a << b[SW-1:0];
            default: y = '0;
        endcase
        flags.zero     = (y == '0);
        flags.negative = y[WIDTH-1];
    end
endmodule

// File: rtl/alu_pipe.sv
// Registered ALU: single-cycle ops land 1 edge after accept, MUL after WIDTH edges.
// in_ready drops while multiplying or while a result is held by out_ready=0.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    logic [0:0]         r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_y;
    flags_t             r_flags;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH-1:0]   w_core_y;
    flags_t             w_core_flags;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_last;
    logic [2*WIDTH-1:0] w_acc_next;
    flags_t             w_mul_flags;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a     (a),
        .b     (b),
        .ctrl  (ctrl),
        .y     (w_core_y),
        .flags (w_core_flags)
    );

    assign in_ready   = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_is_mul   = (ctrl == OP_MUL) && (MUL_EN != 0);
    assign w_mul_last = (r_state == ST_MUL) && (r_cnt == CW'(WIDTH - 1));

    // One shift-add step: multiplicand shifts left, multiplier shifts right.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    assign w_mul_flags.zero     = (w_acc_next[WIDTH-1:0] == '0);
    assign w_mul_flags.negative = w_acc_next[WIDTH-1];
    assign w_mul_flags.carry    = 1'b0;
    assign w_mul_flags.overflow = |w_acc_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_flags     <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
        end else if (r_state == ST_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_mul_last) begin
                r_state     <= ST_IDLE;
                r_out_valid <= 1'b1;
                r_y         <= w_acc_next[WIDTH-1:0];
                r_flags     <= w_mul_flags;
            end
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_state     <= ST_MUL;
                r_out_valid <= 1'b0;
                r_acc       <= '0;
                r_mcand     <= {{WIDTH{1'b0}}, a};
                r_mplier    <= b;
                r_cnt       <= '0;
            end else begin
                r_out_valid <= 1'b1;
                r_y         <= w_core_y;
                r_flags     <= w_core_flags;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign zero      = r_flags.zero;
    assign negative  = r_flags.negative;
    assign carry     = r_flags.carry;
    assign overflow  = r_flags.overflow;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed corner cases, random ops against an arithmetic model,
// backpressure scoreboard, reset abort of MUL, and a MUL_EN=0 instance.
module tb_alu_pipe;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, y;
    logic [2:0] ctrl;
    logic       zero, negative, carry, overflow;

    logic       n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [7:0] n_a, n_b, n_y;
    logic [2:0] n_ctrl;
    logic       n_zero, n_negative, n_carry, n_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8), .MUL_EN(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
    );

    alu_pipe #(.WIDTH(8), .MUL_EN(0)) u_nomul (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .a(n_a), .b(n_b), .ctrl(n_ctrl), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .y(n_y), .zero(n_zero), .negative(n_negative), .carry(n_carry), .overflow(n_overflow)
    );

    // Reference: plain integer arithmetic, packed as {y, zero, negative, carry, overflow}.
    function automatic logic [11:0] ref_alu(input logic [7:0] ra, input logic [7:0] rb,
                                            input logic [2:0] op);
        int ua, ub, sa, sb, r;
        logic c, v;
        logic [7:0] ry;
        ua = int'(ra); ub = int'(rb);
        sa = int'($signed(ra)); sb = int'($signed(rb));
        r = 0; c = 1'b0; v = 1'b0;
        case (op)
            OP_AND: r = ua & ub;
            OP_OR:  r = ua | ub;
            OP_XOR: r = ua ^ ub;
            OP_ADD: begin
                r = ua + ub;
                c = (r > 255);
                v = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            OP_SUB: begin
                r = ua - ub;
                c = (ua < ub);
                v = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            OP_SLT: r = (sa < sb) ? 1 : 0;
            OP_SHL: r = ua << (ub % 8);
            default: begin
                r = ua * ub;
                v = (r > 255);
            end
        endcase
        ry = r[7:0];
        return {ry, (ry == 8'h00), ry[7], c, v};
    endfunction

    function automatic logic [11:0] pk(input logic [7:0] py, input logic z, input logic n,
                                       input logic c, input logic v);
        return {py, z, n, c, v};
    endfunction

    function automatic logic [11:0] obs();
        return {y, zero, negative, carry, overflow};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] op,
                         input string tag, input logic [11:0] want);
        a = ia; b = ib; ctrl = op; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        check({tag, "_vld"}, out_valid, 1);
        check(tag, obs(), want);
    endtask

    task automatic do_mul(input logic [7:0] ma, input logic [7:0] mb);
        int lat;
        lat = -1;
        a = ma; b = mb; ctrl = OP_MUL; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("mul_accept_rdy", in_ready, 1);
        step();
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        for (int k = 1; k <= 20; k++) begin
            check("mul_busy_rdy", in_ready, 0);
            step();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check("mul_latency", lat, 8);
        check("mul_result", obs(), ref_alu(ma, mb, OP_MUL));
    endtask

    logic [11:0] exp_q[$];
    logic [11:0] held, last_exp;
    logic [7:0]  bp_a[4], bp_b[4];
    logic [2:0]  bp_op[4];
    logic [7:0]  ra, rb;
    logic [2:0]  op;
    logic        fire_in, fire_out;
    int          idx, cyc, n_out, n_seen;

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a = 8'h01; b = 8'h01; ctrl = OP_ADD;
        n_in_valid = 1'b0; n_out_ready = 1'b1; n_a = '0; n_b = '0; n_ctrl = OP_AND;

        repeat (3) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", obs(), 12'h000);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        issue(8'hFF, 8'h01, OP_ADD, "add_ff_01", pk(8'h00, 1, 0, 1, 0));
        issue(8'h7F, 8'h01, OP_ADD, "add_7f_01", pk(8'h80, 0, 1, 0, 1));
        issue(8'h03, 8'h05, OP_SUB, "sub_03_05", pk(8'hFE, 0, 1, 1, 0));
        issue(8'h80, 8'h01, OP_SLT, "slt_80_01", pk(8'h01, 0, 0, 0, 0));
        issue(8'h81, 8'h09, OP_SHL, "shl_81_09", pk(8'h02, 0, 0, 0, 0));
        issue(8'h5A, 8'h0F, OP_XOR, "xor_5a_0f", pk(8'h55, 0, 0, 0, 0));

        do_mul(8'h10, 8'h11);
        check("mul_directed", obs(), pk(8'h10, 0, 0, 0, 1));

        // Random ops back-to-back, MUL interleaved (covers drain+accept on the same edge).
        last_exp = obs();
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            ra = 8'($urandom); rb = 8'($urandom);
            if (op == OP_MUL) begin
                do_mul(ra, rb);
            end else begin
                a = ra; b = rb; ctrl = op; in_valid = 1'b1; out_ready = 1'b1;
                #1;
                check("rnd_rdy", in_ready, 1);
                step();
                check("rnd_vld", out_valid, 1);
                check($sformatf("rnd_op%0d", op), obs(), ref_alu(ra, rb, op));
            end
            last_exp = ref_alu(ra, rb, op);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("drain_vld_low", out_valid, 0);
        check("drain_hold_y", obs(), last_exp);

        // Backpressure: out_ready low for cycles 1..3.
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = 8'($urandom); bp_b[i] = 8'($urandom); bp_op[i] = 3'($urandom_range(0, 6));
        end
        idx = 0; cyc = 0; n_out = 0; held = '0;
        exp_q.delete();
        while (!(idx == 4 && exp_q.size() == 0) && cyc < 30) begin
            out_ready = !(cyc >= 1 && cyc <= 3);
            if (idx < 4) begin
                in_valid = 1'b1; a = bp_a[idx]; b = bp_b[idx]; ctrl = bp_op[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (cyc >= 1 && cyc <= 3) begin
                check("bp_stall_rdy", in_ready, 0);
                check("bp_stall_vld", out_valid, 1);
                if (cyc > 1) check("bp_hold", obs(), held);
                held = obs();
            end
            if (fire_out) begin
                check("bp_q_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) check("bp_order", obs(), exp_q.pop_front());
                n_out++;
            end
            if (fire_in) begin
                exp_q.push_back(ref_alu(bp_a[idx], bp_b[idx], bp_op[idx]));
                idx++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_count", n_out, 4);
        check("bp_cycles", cyc, 8);

        // Reset in the middle of a multiply must drop it.
        a = 8'h10; b = 8'h11; ctrl = OP_MUL; in_valid = 1'b1;
        #1;
        check("rmul_rdy", in_ready, 1);
        step();
        in_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rmul_vld", out_valid, 0);
        check("rmul_outputs", obs(), 12'h000);
        #1;
        check("rmul_idle_rdy", in_ready, 1);
        n_seen = 0;
        repeat (12) begin
            step();
            if (out_valid) n_seen++;
        end
        check("rmul_no_result", n_seen, 0);

        // MUL_EN=0 build: MUL returns zero in one cycle.
        n_a = 8'h10; n_b = 8'h11; n_ctrl = OP_MUL; n_in_valid = 1'b1; n_out_ready = 1'b1;
        #1;
        check("nomul_rdy", n_in_ready, 1);
        step();
        n_in_valid = 1'b0;
        check("nomul_vld", n_out_valid, 1);
        check("nomul_res", {n_y, n_zero, n_negative, n_carry, n_overflow}, pk(8'h00, 1, 0, 0, 0));
        step();
        check("nomul_drain", n_out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
